// File: rtl/fir_folded_mac.sv
// Time-multiplexed FIR filter: a single multiplier and accumulator are shared across all
// taps. Each sample is rounded, saturated and presented on a valid/ready output stream.
module fir_folded_mac #(
    parameter int DATA_W    = 16,
    parameter int COEF_W    = 16,
    parameter int COEF_FRAC = 15,
    parameter int TAPS      = 100,
    parameter int ACC_W     = DATA_W + COEF_W + $clog2(TAPS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [COEF_W-1:0]        coef_wdata,
    output logic                     coef_ready,
    input  logic                     clear,
    output logic                     sat_flag
);

    localparam int AW = $clog2(TAPS);
    localparam int FW = $clog2(TAPS + 1);
    localparam int PW = DATA_W + COEF_W;
    localparam int RW = ACC_W + 1;

    localparam logic [AW-1:0]        K_LAST    = AW'(TAPS - 1);
    localparam logic [AW:0]          TAPS_X    = (AW + 1)'(TAPS);
    localparam logic [AW:0]          TAPS_M1_X = (AW + 1)'(TAPS - 1);
    localparam logic [FW-1:0]        FILL_MAX  = FW'(TAPS);
    localparam logic [AW-1:0]        ONE_A     = {{(AW - 1){1'b0}}, 1'b1};
    localparam logic [FW-1:0]        ONE_F     = {{(FW - 1){1'b0}}, 1'b1};
    localparam logic signed [RW-1:0] RND       = {{(RW - COEF_FRAC){1'b0}}, 1'b1, {(COEF_FRAC - 1){1'b0}}};
    localparam logic signed [RW-1:0] SAT_MAX   = {{(RW - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN   = {{(RW - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_MAC   = 2'd1,
        S_DRAIN = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t                    state_q, state_d;
    logic [AW-1:0]             k_q, k_d;
    logic [AW-1:0]             wptr_q;
    logic [FW-1:0]             fill_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [PW-1:0]      p_q;
    logic signed [DATA_W-1:0]  hist_q [TAPS];
    logic signed [COEF_W-1:0]  coef_q [TAPS];
    logic [DATA_W-1:0]         out_data_q;
    logic                      out_valid_q;
    logic                      sat_q;
    logic                      in_ready_q;
    logic                      coef_ready_q;

    logic                      accept_s;
    logic                      coef_wr_s;
    logic [AW:0]               idx_s;
    logic signed [DATA_W-1:0]  x_s;
    logic signed [ACC_W-1:0]   p_ext_s;
    logic signed [RW-1:0]      rnd_s;
    logic signed [RW-1:0]      shr_s;
    logic [DATA_W-1:0]         res_s;
    logic                      clip_s;

    // clear wins over a sample offered on the same IDLE cycle
    assign accept_s  = (state_q == S_IDLE) && in_ready_q && in_valid && !clear;
    assign coef_wr_s = (state_q == S_IDLE) && coef_ready_q && coef_we && (int'(coef_addr) < TAPS);
    assign p_ext_s   = ACC_W'(p_q);

    assign in_ready   = in_ready_q;
    assign coef_ready = coef_ready_q;
    assign out_data   = out_data_q;
    assign out_valid  = out_valid_q;
    assign sat_flag   = sat_q;

    // Operand fetch: tap k reads the k-th newest sample, zero beyond the filled depth
    always_comb begin
        idx_s = {1'b0, wptr_q} + TAPS_M1_X - {1'b0, k_q};
        if (idx_s >= TAPS_X) begin
            idx_s = idx_s - TAPS_X;
        end else begin
            idx_s = idx_s;
        end
        if (FW'(k_q) < fill_q) begin
            x_s = hist_q[idx_s[AW-1:0]];
        end else begin
            x_s = {DATA_W{1'b0}};
        end
    end

    // Round half up, arithmetic shift, then clip to the output range
    always_comb begin
        rnd_s = RW'(acc_q) + RND;
        shr_s = rnd_s >>> COEF_FRAC;
        if (shr_s > SAT_MAX) begin
            res_s  = SAT_MAX[DATA_W-1:0];
            clip_s = 1'b1;
        end else if (shr_s < SAT_MIN) begin
            res_s  = SAT_MIN[DATA_W-1:0];
            clip_s = 1'b1;
        end else begin
            res_s  = shr_s[DATA_W-1:0];
            clip_s = 1'b0;
        end
    end

    // Next-state and tap-index logic
    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    state_d = S_MAC;
                    k_d     = {AW{1'b0}};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_MAC: begin
                if (k_q == K_LAST) begin
                    state_d = S_DRAIN;
                end else begin
                    k_d = k_q + ONE_A;
                end
            end
            S_DRAIN: state_d = S_HOLD;
            S_HOLD: begin
                if (out_valid_q && out_ready) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_HOLD;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register; ready flags are registered so they stay low throughout reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            k_q          <= {AW{1'b0}};
            in_ready_q   <= 1'b0;
            coef_ready_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_q          <= k_d;
            in_ready_q   <= (state_d == S_IDLE);
            coef_ready_q <= (state_d == S_IDLE);
        end
    end

    // MAC datapath, history bookkeeping and output register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q      <= {AW{1'b0}};
            fill_q      <= {FW{1'b0}};
            acc_q       <= {ACC_W{1'b0}};
            p_q         <= {PW{1'b0}};
            out_data_q  <= {DATA_W{1'b0}};
            out_valid_q <= 1'b0;
            sat_q       <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept_s) begin
                        acc_q  <= {ACC_W{1'b0}};
                        p_q    <= {PW{1'b0}};
                        wptr_q <= (wptr_q == K_LAST) ? {AW{1'b0}} : (wptr_q + ONE_A);
                        fill_q <= (fill_q == FILL_MAX) ? fill_q : (fill_q + ONE_F);
                    end else if (clear) begin
                        wptr_q <= {AW{1'b0}};
                        fill_q <= {FW{1'b0}};
                    end
                end
                S_MAC: begin
                    p_q   <= x_s * coef_q[k_q];
                    acc_q <= acc_q + p_ext_s;
                end
                S_DRAIN: acc_q <= acc_q + p_ext_s;
                S_HOLD: begin
                    // first HOLD cycle loads the result; later cycles wait for the consumer
                    if (!out_valid_q) begin
                        out_data_q  <= res_s;
                        out_valid_q <= 1'b1;
                        sat_q       <= sat_q | clip_s;
                    end else if (out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: out_valid_q <= 1'b0;
            endcase
        end
    end

    // Sample history and coefficient storage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < TAPS; i++) begin
                hist_q[i] <= {DATA_W{1'b0}};
                coef_q[i] <= {COEF_W{1'b0}};
            end
        end else begin
            if (accept_s) begin
                hist_q[wptr_q] <= $signed(in_data);
            end
            if (coef_wr_s) begin
                coef_q[coef_addr] <= $signed(coef_wdata);
            end
        end
    end

endmodule

// File: tb/tb_fir_folded_mac.sv
// Randomised self-checking bench for fir_folded_mac (TAPS=8) against a queue-based model
// that applies the filter definition directly.
module tb_fir_folded_mac;

    localparam int TAPS = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic        coef_we;
    logic [2:0]  coef_addr;
    logic [15:0] coef_wdata;
    logic        coef_ready;
    logic        clear;
    logic        sat_flag;

    int n_tests = 0;
    int n_fail  = 0;

    int h_m [TAPS];
    int hist_m [$];
    bit sat_m;

    fir_folded_mac #(
        .DATA_W(16), .COEF_W(16), .COEF_FRAC(15), .TAPS(TAPS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
        .coef_ready(coef_ready), .clear(clear), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    // y = sat(round(sum_k h[k] * x[n-k] / 2^15)), with missing history treated as zero
    function automatic logic [15:0] model_out(output bit clipped);
        longint acc;
        longint r;
        acc = 0;
        for (int k = 0; k < hist_m.size(); k++) begin
            acc += longint'(hist_m[k]) * longint'(h_m[k]);
        end
        r = (acc + 64'sd16384) >>> 15;
        clipped = 1'b0;
        if (r > 32767) begin
            r = 32767;
            clipped = 1'b1;
        end else if (r < -32768) begin
            r = -32768;
            clipped = 1'b1;
        end
        return r[15:0];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < TAPS; i++) h_m[i] = 0;
        hist_m.delete();
        sat_m = 1'b0;
    endtask

    task automatic wait_ready(output bit ok);
        int n;
        n = 0;
        while (in_ready !== 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        ok = (in_ready === 1'b1);
        if (!ok) chk("ready_timeout", 64'd0, 64'd1);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_sat_flag", sat_flag, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_coef_ready", coef_ready, 0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        chk("rel_in_ready_before_clk", in_ready, 0);
        @(posedge clk); #1;
        chk("rel_in_ready", in_ready, 1);
        chk("rel_coef_ready", coef_ready, 1);
    endtask

    task automatic write_coef(input logic [2:0] a, input logic [15:0] d);
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        coef_we = 1'b1; coef_addr = a; coef_wdata = d;
        @(posedge clk); #1;
        coef_we = 1'b0;
        h_m[a] = int'($signed(d));
    endtask

    task automatic do_clear();
        bit ok;
        wait_ready(ok);
        if (!ok) return;
        clear = 1'b1; in_valid = 1'b1; in_data = 16'h1234;
        @(posedge clk); #1;
        clear = 1'b0; in_valid = 1'b0;
        hist_m.delete();
        chk("clear_blocks_sample", in_ready, 1);
    endtask

    task automatic send(input string tag, input logic [15:0] d, input int hold, input bit busy_wr,
                        input bit co_wr, input logic [2:0] ca, input logic [15:0] cd);
        bit ok;
        bit clipped;
        int n;
        logic [15:0] expv;
        logic [15:0] held;
        wait_ready(ok);
        if (!ok) return;
        in_data = d; in_valid = 1'b1;
        if (co_wr) begin
            coef_we = 1'b1; coef_addr = ca; coef_wdata = cd;
            h_m[ca] = int'($signed(cd));
        end
        @(posedge clk); #1;
        in_valid = 1'b0; coef_we = 1'b0;
        hist_m.push_front(int'($signed(d)));
        if (hist_m.size() > TAPS) void'(hist_m.pop_back());
        expv = model_out(clipped);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            if (busy_wr && n == 2) begin
                coef_we = 1'b1; coef_addr = 3'd0; coef_wdata = 16'h4000;
            end else begin
                coef_we = 1'b0;
            end
            @(posedge clk); #1;
            n++;
        end
        coef_we = 1'b0;
        chk({tag, "_latency"}, n, TAPS + 2);
        held = out_data;
        for (int i = 0; i < hold; i++) begin
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_valid", out_valid, 1);
            @(posedge clk); #1;
            chk("bp_data_stable", out_data, held);
        end
        chk({tag, "_data"}, out_data, expv);
        if (clipped) sat_m = 1'b1;
        chk({tag, "_sat_flag"}, sat_flag, sat_m);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, "_valid_drop"}, out_valid, 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        rst_n = 1'b0; in_data = 16'h0000; in_valid = 1'b0; out_ready = 1'b0;
        coef_we = 1'b0; coef_addr = 3'd0; coef_wdata = 16'h0000; clear = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // impulse through all-0.5 coefficients
        for (int k = 0; k < TAPS; k++) write_coef(3'(k), 16'h4000);
        do_clear();
        send("impulse", 16'h2000, 0, 1'b0, 1'b0, 3'd0, 16'h0000);
        for (int i = 0; i < 15; i++) send("impulse_tail", 16'h0000, 0, 1'b0, 1'b0, 3'd0, 16'h0000);

        // rounding at the half-LSB boundary
        for (int k = 0; k < TAPS; k++) write_coef(3'(k), (k == 0) ? 16'h0001 : 16'h0000);
        do_clear();
        send("round_pos", 16'h4000, 0, 1'b0, 1'b0, 3'd0, 16'h0000);
        send("round_below", 16'h3FFF, 0, 1'b0, 1'b0, 3'd0, 16'h0000);
        send("round_neg", 16'hC000, 0, 1'b0, 1'b0, 3'd0, 16'h0000);

        // saturation both ways
        for (int k = 0; k < TAPS; k++) write_coef(3'(k), 16'h7FFF);
        do_clear();
        for (int i = 0; i < TAPS; i++) send("sat_pos", 16'h7FFF, 0, 1'b0, 1'b0, 3'd0, 16'h0000);
        chk("sat_flag_set", sat_flag, 1);
        do_reset();
        for (int k = 0; k < TAPS; k++) write_coef(3'(k), 16'h7FFF);
        for (int i = 0; i < TAPS; i++) send("sat_neg", 16'h8000, 0, 1'b0, 1'b0, 3'd0, 16'h0000);

        // backpressure with a single-sample history
        do_clear();
        for (int k = 0; k < TAPS; k++) write_coef(3'(k), 16'(k + 1));
        send("backpressure", 16'h8000, 20, 1'b0, 1'b0, 3'd0, 16'h0000);

        // coefficient write during MAC is dropped; same-cycle write with a sample is used
        send("busy_write", 16'h0100, 0, 1'b1, 1'b0, 3'd0, 16'h0000);
        send("after_busy", 16'h0300, 0, 1'b0, 1'b0, 3'd0, 16'h0000);
        send("same_cycle_wr", 16'h0200, 0, 1'b0, 1'b1, 3'd0, 16'h2000);

        // reset in the middle of MAC
        wait_ready(ok);
        in_data = 16'h1000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        send("post_reset", 16'h1234, 0, 1'b0, 1'b0, 3'd0, 16'h0000);

        // random traffic
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 7) == 0) do_clear();
            if ($urandom_range(0, 3) == 0) write_coef(3'($urandom_range(0, 7)), 16'($urandom));
            send("rand", 16'($urandom), int'($urandom_range(0, 3)), 1'b0,
                 ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), 16'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
